// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared op encodings, FSM state type and word width for the MIPS multiply/divide unit
package mips_pkg;

    localparam int WORD_W = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/md_sign_fix.sv
// rtl/md_sign_fix.sv - combinational conditional two's-complement helper for the multiply/divide unit
//
// Ports:
//   hi_i, lo_i      : upper/lower word in
//   neg_hi_i        : negate hi_i on its own (split mode only)
//   neg_lo_i        : negate lo_i on its own, or the joined 2W value in join mode
//   join_i          : treat {hi_i, lo_i} as one 2W value (product correction)
//   hi_o, lo_o      : corrected words out
module md_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic             neg_hi_i,
    input  logic             neg_lo_i,
    input  logic             join_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [2*WIDTH-1:0] wide_neg;

    assign wide_neg = -{hi_i, lo_i};

    always_comb begin
        hi_o = hi_i;
        lo_o = lo_i;
        if (join_i) begin
            if (neg_lo_i) begin
                {hi_o, lo_o} = wide_neg;
            end
        end else begin
            if (neg_hi_i) begin
                hi_o = -hi_i;
            end
            if (neg_lo_i) begin
                lo_o = -lo_i;
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative 32-bit MULT/MULTU/DIV/DIVU engine feeding the HI/LO register pair
//
// Optional macro MULT_DIV_FLUSH_EN adds the flush input (squash of an in-flight operation).
//
// Ports:
//   clock, reset_n         : rising-edge clock, asynchronous active-low reset
//   start, op              : request pulse and operation (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   operand_a, operand_b   : rs / rt operands, latched when start is accepted
//   flush                  : (MULT_DIV_FLUSH_EN only) abort in CALC/FIX/DONE
//   busy                   : high in CALC and FIX
//   hi_result, lo_result   : product high/low, or remainder/quotient
//   hi_lo_write_enable     : one-cycle strobe in DONE; results valid that cycle
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
`ifdef MULT_DIV_FLUSH_EN
    input  logic             flush,
`endif
    output logic             busy,
    output logic [WIDTH-1:0] hi_result,
    output logic [WIDTH-1:0] lo_result,
    output logic             hi_lo_write_enable
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       op_q;
    logic             sign_a_q;
    logic             sign_b_q;
    logic             b_zero_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] acc_hi_q;
    logic [WIDTH-1:0] acc_lo_q;
    logic [WIDTH-1:0] acc_hi_d;
    logic [WIDTH-1:0] acc_lo_d;
    logic             busy_q;
    logic             we_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             flush_w;
    logic             accept_w;
    logic             in_signed_w;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;
    logic             out_signed_w;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;

`ifdef MULT_DIV_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    assign in_signed_w  = op_is_signed(op);
    assign out_signed_w = op_is_signed(op_q);
    assign accept_w     = start && !flush_w &&
                          ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Operand magnitudes; the signs are kept separately for the FIX step.
    md_sign_fix #(.WIDTH(WIDTH)) u_in_fix (
        .hi_i     (operand_a),
        .lo_i     (operand_b),
        .neg_hi_i (in_signed_w & operand_a[WIDTH-1]),
        .neg_lo_i (in_signed_w & operand_b[WIDTH-1]),
        .join_i   (1'b0),
        .hi_o     (mag_a),
        .lo_o     (mag_b)
    );

    // Product sign spans the whole 2W value; for divide the quotient follows
    // sign_a^sign_b and the remainder follows the dividend.
    md_sign_fix #(.WIDTH(WIDTH)) u_out_fix (
        .hi_i     (acc_hi_q),
        .lo_i     (acc_lo_q),
        .neg_hi_i (out_signed_w & sign_a_q),
        .neg_lo_i (out_signed_w & (sign_a_q ^ sign_b_q)),
        .join_i   (!op_is_div(op_q)),
        .hi_o     (fix_hi),
        .lo_o     (fix_lo)
    );

    // One iteration: multiply adds the multiplicand into the high half when
    // the current multiplier bit is set, then shifts the 2W accumulator right.
    // Divide shifts the next dividend bit into the partial remainder and keeps
    // the trial subtraction when it does not borrow (restoring division).
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, mcand_q};
        acc_hi_d  = mul_sum[WIDTH:1];
        acc_lo_d  = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        if (op_is_div(op_q)) begin
            if (!div_diff[WIDTH+1]) begin
                acc_hi_d = div_diff[WIDTH-1:0];
                acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_hi_d = div_shift[WIDTH-1:0];
                acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MULT;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_zero_q <= 1'b0;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            busy_q   <= 1'b0;
            we_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    we_q <= 1'b0;
                    if (accept_w) begin
                        state_q  <= ST_CALC;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        op_q     <= op;
                        sign_a_q <= in_signed_w & operand_a[WIDTH-1];
                        sign_b_q <= in_signed_w & operand_b[WIDTH-1];
                        b_zero_q <= (operand_b == '0);
                        mcand_q  <= mag_b;
                        acc_hi_q <= '0;
                        acc_lo_q <= mag_a;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_CALC: begin
                    if (flush_w) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_hi_q <= acc_hi_d;
                        acc_lo_q <= acc_lo_d;
                        cnt_q    <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            state_q <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    busy_q <= 1'b0;
                    if (flush_w) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_DONE;
                        we_q    <= 1'b1;
                        // fix_hi already restores the original dividend for /0.
                        hi_q    <= fix_hi;
                        lo_q    <= (op_is_div(op_q) && b_zero_q) ? '1 : fix_lo;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign busy               = busy_q;
    assign hi_result          = hi_q;
    assign lo_result          = lo_q;
    // A flush in DONE must squash the strobe already standing in that cycle.
    assign hi_lo_write_enable = we_q & ~flush_w;

endmodule
